// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - per-pin synchroniser, stable-count debounce, edge pulses, sticky IRQ pending (IRQ logic built only with GPIO_IN_FILTER_IRQ_EN)
module gpio_in_filter #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_pend_o,
  output logic             irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync;
  logic [CNT_W-1:0] cnt   [WIDTH];
  logic [CNT_W-1:0] cnt_n [WIDTH];
  logic [WIDTH-1:0] data_n;
  logic [WIDTH-1:0] rise_n;
  logic [WIDTH-1:0] fall_n;

  // Per-pin debounce decision: restart on disable or agreement, accept after a full stable run
  always_comb begin
    data_n = data_o;
    rise_n = '0;
    fall_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_n[i] = cnt[i];
      if (!en_i || (sync[i] == data_o[i])) begin
        cnt_n[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        data_n[i] = sync[i];
        cnt_n[i]  = '0;
        rise_n[i] = sync[i];
        fall_n[i] = ~sync[i];
      end else begin
        cnt_n[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Synchroniser, counters, filtered level and edge pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync   <= '0;
      data_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync   <= data_i;
      data_o <= data_n;
      rise_o <= rise_n;
      fall_o <= fall_n;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_n[i];
      end
    end
  end

`ifdef GPIO_IN_FILTER_IRQ_EN
  logic [WIDTH-1:0] irq_set;

  // An enabled edge lands in the same edge as the level update; set beats clear
  assign irq_set = (rise_n & rise_en_i) | (fall_n & fall_en_i);

  // Sticky pending flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_pend_o <= '0;
    end else begin
      irq_pend_o <= irq_set | (irq_pend_o & ~irq_clr_i);
    end
  end

  assign irq_o = |irq_pend_o;
`else
  logic unused_irq_inputs;

  // Interrupt controls have no effect in this build
  assign unused_irq_inputs = ^{rise_en_i, fall_en_i, irq_clr_i};
  assign irq_pend_o        = '0;
  assign irq_o             = 1'b0;
`endif

endmodule
